// File: rtl/spi_sensor_responder.sv
// spi_sensor_responder: SPI responder modelling the 8-bit light-sensor ADC.
// ss/sclk are oversampled on clk; each frame shifts {4'b0, sample, 4'b0} out
// on miso, MSB first, one bit per sclk rise. Samples arrive over valid/ready
// into a one-entry holding register.
// Build option SPI_RESP_SYNC2_EN: two-flop input synchronizer (S = 2);
// otherwise a single register stage (S = 1).
module spi_sensor_responder #(
  parameter int FRAME_BITS = 16,
  parameter int DATA_LSB   = 4,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ss,
  input  logic              sclk,
  output logic              miso,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              underrun
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, TAIL} state_t;

  logic ss_s, sclk_s, ss_d, sclk_d;
  logic ss_fall, ss_rise, sclk_rise;

  // Synchronizer flops reset low so an ss already low at reset release is
  // not mistaken for a falling edge; the block waits for ss high then low.
`ifdef SPI_RESP_SYNC2_EN
  logic ss_m, sclk_m;

  // Two-stage synchronizer for genuinely asynchronous pins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ss_m   <= 1'b0;
      sclk_m <= 1'b0;
      ss_s   <= 1'b0;
      sclk_s <= 1'b0;
    end else begin
      ss_m   <= ss;
      sclk_m <= sclk;
      ss_s   <= ss_m;
      sclk_s <= sclk_m;
    end
  end
`else
  // Single register stage for same-clock or loop-back use.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ss_s   <= 1'b0;
      sclk_s <= 1'b0;
    end else begin
      ss_s   <= ss;
      sclk_s <= sclk;
    end
  end
`endif

  // Delayed copy of the synchronized pins for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ss_d   <= 1'b0;
      sclk_d <= 1'b0;
    end else begin
      ss_d   <= ss_s;
      sclk_d <= sclk_s;
    end
  end

  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ss_s & ~ss_d;
  assign sclk_rise = sclk_s & ~sclk_d;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d, frame_load;
  logic [DATA_W-1:0]       hold, hold_d;
  logic                    hold_full, hold_full_d;
  logic                    miso_d, done_d, abort_d, under_d;

  assign frame_load   = {{(FRAME_BITS-DATA_W){1'b0}}, hold} << DATA_LSB;
  assign sample_ready = ~hold_full;
  assign busy         = (state_q != IDLE);

  // Frame FSM, shifter, holding register and event pulses: next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    miso_d      = miso;
    hold_d      = hold;
    hold_full_d = hold_full;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    under_d     = 1'b0;

    if (state_q != IDLE && ss_rise) begin
      // End of frame: complete only if every frame bit went out.
      state_d = IDLE;
      miso_d  = 1'b0;
      cnt_d   = '0;
      if (state_q == TAIL || (state_q == SHIFT && cnt_q == CNT_FULL))
        done_d  = 1'b1;
      else
        abort_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          cnt_d  = '0;
          if (ss_fall) begin
            // Capture always; an empty holder means the last sample is resent.
            hold_full_d = 1'b0;
            under_d     = ~hold_full;
            if (sclk_rise) begin
              // Coincident first edge counts as bit 1.
              miso_d  = frame_load[FRAME_BITS-1];
              shreg_d = {frame_load[FRAME_BITS-2:0], 1'b0};
              cnt_d   = CNT_W'(1);
              state_d = SHIFT;
            end else begin
              shreg_d = frame_load;
              state_d = ARMED;
            end
          end
        end
        ARMED: begin
          if (sclk_rise) begin
            miso_d  = shreg_q[FRAME_BITS-1];
            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            if (cnt_q < CNT_FULL) begin
              miso_d  = shreg_q[FRAME_BITS-1];
              shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
              cnt_d   = cnt_q + 1'b1;
            end else begin
              miso_d  = 1'b0;
              state_d = TAIL;
            end
          end
        end
        TAIL: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end

    // Producer write uses the pre-capture flag, so a same-cycle capture
    // takes the old value and the new sample refills the holder.
    if (sample_valid && !hold_full) begin
      hold_d      = sample_data;
      hold_full_d = 1'b1;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      miso        <= 1'b0;
      hold        <= '0;
      hold_full   <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      miso        <= miso_d;
      hold        <= hold_d;
      hold_full   <= hold_full_d;
      frame_done  <= done_d;
      frame_abort <= abort_d;
      underrun    <= under_d;
    end
  end

endmodule
